// File: rtl/arbitro_decodificador.sv
// Round-robin arbiter sharing one SECDED(8,4) decoder between two requesters.
// Latency: result valid LAT_DEC+1 cycles after the handshake; res held under res_ready=0.
module arbitro_decodificador #(
  parameter int LAT_DEC = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_palabra,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_palabra,
  output logic             req1_ready,
  output logic [7:0]       dec_palabra,
  input  logic [3:0]       dec_pos_error,
  input  logic [4:0]       dec_w_corregida,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [3:0]       res_dato,
  output logic             res_doble,
  output logic [3:0]       res_pos_error,
  output logic [CNT_W-1:0] cnt_simple,
  output logic [CNT_W-1:0] cnt_doble,
  input  logic             clr_cnt,
  output logic             ocupado
);

  typedef enum logic [1:0] {INACTIVO, ESPERA, RESPUESTA} estado_t;

  localparam int CW = (LAT_DEC < 2) ? 1 : $clog2(LAT_DEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t       state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          id_q;
  logic          prio;
  logic          gnt_vld;
  logic          gnt_id;
  logic          handshake;
  logic          capture;
  logic          res_hs;

  // Both valid: the pointer decides; otherwise the lone requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = prio;
    end else if (req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end else if (req0_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end
  end

  assign handshake = (state == INACTIVO) && gnt_vld;
  assign capture   = (state == ESPERA) && (wait_cnt == CW'(1));
  assign res_hs    = (state == RESPUESTA) && res_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= INACTIVO;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INACTIVO:  if (handshake) state_next = ESPERA;
      ESPERA:    if (capture)   state_next = RESPUESTA;
      RESPUESTA: if (res_hs)    state_next = INACTIVO;
      default:                  state_next = INACTIVO;
    endcase
  end

  always_comb begin
    req0_ready = (state == INACTIVO) && gnt_vld && !gnt_id;
    req1_ready = (state == INACTIVO) && gnt_vld &&  gnt_id;
    res_valid  = (state == RESPUESTA);
    ocupado    = (state != INACTIVO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_palabra   <= '0;
      id_q          <= 1'b0;
      prio          <= 1'b0;
      wait_cnt      <= '0;
      res_id        <= 1'b0;
      res_dato      <= '0;
      res_doble     <= 1'b0;
      res_pos_error <= '0;
    end else begin
      if (handshake) begin
        dec_palabra <= gnt_id ? req1_palabra : req0_palabra;
        id_q        <= gnt_id;
        prio        <= ~gnt_id;
        wait_cnt    <= CW'(LAT_DEC);
      end else if (state == ESPERA) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
      if (capture) begin
        res_id        <= id_q;
        res_dato      <= dec_w_corregida[3:0];
        res_doble     <= dec_w_corregida[4];
        res_pos_error <= dec_pos_error;
      end
    end
  end

  // A clear coinciding with a capture wins over the increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (capture) begin
      if (dec_w_corregida[4]) begin
        if (cnt_doble != CNT_MAX) cnt_doble <= cnt_doble + 1'b1;
      end else if (dec_pos_error != 4'd0) begin
        if (cnt_simple != CNT_MAX) cnt_simple <= cnt_simple + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_decodificador.sv
// Directed bench for arbitro_decodificador (LAT_DEC=1); a CNT_W=2 copy shares the stimulus
// to exercise counter saturation.
module tb_arbitro_decodificador;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_palabra, req1_palabra;
  logic [3:0] dec_pos_error;
  logic [4:0] dec_w_corregida;
  logic       res_ready;
  logic       clr_cnt;

  logic       req0_ready, req1_ready, res_valid, res_id, res_doble, ocupado;
  logic [7:0] dec_palabra;
  logic [3:0] res_dato, res_pos_error;
  logic [7:0] cnt_simple, cnt_doble;

  logic       s_req0_ready, s_req1_ready, s_res_valid, s_res_id, s_res_doble, s_ocupado;
  logic [7:0] s_dec_palabra;
  logic [3:0] s_res_dato, s_res_pos_error;
  logic [1:0] s_cnt_simple, s_cnt_doble;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitro_decodificador #(.LAT_DEC(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_palabra(req0_palabra), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_palabra(req1_palabra), .req1_ready(req1_ready),
    .dec_palabra(dec_palabra), .dec_pos_error(dec_pos_error), .dec_w_corregida(dec_w_corregida),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_dato(res_dato),
    .res_doble(res_doble), .res_pos_error(res_pos_error),
    .cnt_simple(cnt_simple), .cnt_doble(cnt_doble), .clr_cnt(clr_cnt), .ocupado(ocupado)
  );

  arbitro_decodificador #(.LAT_DEC(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_palabra(req0_palabra), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_palabra(req1_palabra), .req1_ready(s_req1_ready),
    .dec_palabra(s_dec_palabra), .dec_pos_error(dec_pos_error), .dec_w_corregida(dec_w_corregida),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_id(s_res_id), .res_dato(s_res_dato),
    .res_doble(s_res_doble), .res_pos_error(s_res_pos_error),
    .cnt_simple(s_cnt_simple), .cnt_doble(s_cnt_doble), .clr_cnt(clr_cnt), .ocupado(s_ocupado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with res_ready=1; only requester `id` is valid.
  task automatic do_txn(input logic id, input logic [7:0] pal, input logic [3:0] pos,
                        input logic [4:0] res, input logic clr_cap);
    @(negedge clk);
    req0_valid = !id; req1_valid = id;
    req0_palabra = pal; req1_palabra = pal;
    dec_pos_error = pos; dec_w_corregida = res; res_ready = 1'b1;
    #1;
    chk("grant_ready", 32'(id ? req1_ready : req0_ready), 32'd1);
    chk("other_ready", 32'(id ? req0_ready : req1_ready), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    clr_cnt = clr_cap;
    #1;
    chk("dec_palabra", 32'(dec_palabra), 32'(pal));
    chk("wait_res_valid", 32'(res_valid), 32'd0);
    chk("wait_ocupado", 32'(ocupado), 32'd1);
    chk("wait_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_id", 32'(res_id), 32'(id));
    chk("res_dato", 32'(res_dato), 32'(res[3:0]));
    chk("res_doble", 32'(res_doble), 32'(res[4]));
    chk("res_pos_error", 32'(res_pos_error), 32'(pos));
    chk("s_res_valid", 32'(s_res_valid), 32'd1);
    chk("s_res_id", 32'(s_res_id), 32'(id));
    chk("s_res_dato", 32'(s_res_dato), 32'(res[3:0]));
    chk("s_res_doble", 32'(s_res_doble), 32'(res[4]));
    chk("s_res_pos_error", 32'(s_res_pos_error), 32'(pos));
    @(negedge clk);
    #1;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("back_idle", 32'(ocupado), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr_cnt = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_palabra = 8'h00; req1_palabra = 8'h00;
    dec_pos_error = 4'h0; dec_w_corregida = 5'h00;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_dec_palabra", 32'(dec_palabra), 32'd0);
    chk("rst_res_fields", {res_id, res_doble, res_dato, res_pos_error}, 32'd0);
    chk("rst_counters", {cnt_simple, cnt_doble}, 32'd0);
    chk("rst_readies", {req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;

    // Single clean word from requester 0
    do_txn(1'b0, 8'h00, 4'h0, 5'b00000, 1'b0);
    chk("clean_counters", {cnt_simple, cnt_doble}, 32'd0);

    // Both requesters valid continuously: grants 0,1,0,1 every 3 cycles
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0_valid = 1'b1; req0_palabra = 8'h11;
    req1_valid = 1'b1; req1_palabra = 8'h22;
    dec_pos_error = 4'h0; dec_w_corregida = 5'h0A; res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("alt_ready0", 32'(req0_ready), 32'((k % 6) == 0));
      chk("alt_ready1", 32'(req1_ready), 32'((k % 6) == 3));
      if ((k % 3) == 1) chk("alt_dec_palabra", 32'(dec_palabra), ((k % 6) == 1) ? 32'h11 : 32'h22);
      if ((k % 3) == 2) begin
        chk("alt_res_id", 32'(res_id), 32'((k % 6) == 5));
        chk("alt_res_dato", 32'(res_dato), 32'hA);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("alt_counters", {cnt_simple, cnt_doble}, 32'd0);

    // Single error from requester 1
    do_txn(1'b1, 8'h5A, 4'b0101, 5'b01011, 1'b0);
    chk("single_cnt_simple", 32'(cnt_simple), 32'd1);
    chk("single_cnt_doble", 32'(cnt_doble), 32'd0);

    // Double error held under 5 cycles of backpressure
    @(negedge clk);
    req0_valid = 1'b1; req0_palabra = 8'hC3;
    dec_pos_error = 4'b1110; dec_w_corregida = 5'b10000; res_ready = 1'b0;
    #1;
    chk("dbl_grant", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_palabra = 8'h77;
    #1;
    chk("dbl_wait_ready1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin dec_w_corregida = 5'h0F; dec_pos_error = 4'h0; end
      #1;
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res", {res_id, res_doble, res_dato, res_pos_error}, 32'b0_1_0000_1110);
      chk("hold_ready1", 32'(req1_ready), 32'd0);
      chk("hold_counters", {cnt_simple, cnt_doble}, {16'd0, 8'd1, 8'd1});
    end
    res_ready = 1'b1; req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("dbl_release", 32'(res_valid), 32'd0);
    chk("dbl_release_idle", 32'(ocupado), 32'd0);

    // Four more single errors: 8-bit counter reaches 5, 2-bit copy saturates at 3
    for (int i = 0; i < 4; i++) do_txn(i[0], 8'h30 + 8'(i), 4'b0010, 5'b00110, 1'b0);
    chk("sat_cnt_simple_w8", 32'(cnt_simple), 32'd5);
    chk("sat_cnt_simple_w2", 32'(s_cnt_simple), 32'd3);
    chk("sat_cnt_doble_w2", 32'(s_cnt_doble), 32'd1);
    chk("sat_idle", {s_ocupado, s_req0_ready, s_req1_ready}, 32'd0);
    chk("sat_dec_palabra", 32'(s_dec_palabra), 32'h33);

    // Reset during ESPERA discards the in-flight word
    @(negedge clk);
    req0_valid = 1'b1; req0_palabra = 8'h99;
    dec_pos_error = 4'b0001; dec_w_corregida = 5'b00001;
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b1;
    #1;
    chk("pre_rst_ocupado", 32'(ocupado), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
    chk("mid_rst_dec_palabra", 32'(dec_palabra), 32'd0);
    chk("mid_rst_counters", {cnt_simple, cnt_doble}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mid_rst_no_valid", 32'(res_valid), 32'd0);
    end

    // Clear coinciding with a capture wins
    do_txn(1'b0, 8'h0F, 4'b0100, 5'b00111, 1'b0);
    chk("pre_clr_cnt_simple", 32'(cnt_simple), 32'd1);
    do_txn(1'b1, 8'hE1, 4'b1001, 5'b10000, 1'b1);
    chk("clr_cnt_simple", 32'(cnt_simple), 32'd0);
    chk("clr_cnt_doble", 32'(cnt_doble), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
